// File: rtl/ks_nibble_seq_ctrl_if.sv
// Bus bundle for the nibble-serial Kogge-Stone adder sequencer.
// master drives requests and operands; slave returns result and status.
interface ks_nibble_seq_ctrl_if #(
    parameter int NIBBLES = 4
) ();
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         clr;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic         done;

    modport master (
        output start, clr, op_a, op_b, cin,
        input  sum, cout, ovf, busy, done
    );

    modport slave (
        input  start, clr, op_a, op_b, cin,
        output sum, cout, ovf, busy, done
    );
endinterface

// File: rtl/ks_nibble_seq_ctrl.sv
// Nibble-serial adder: one 4-bit Kogge-Stone core reused NIBBLES times.
// Define KS_SEQ_OVF_EN to build the signed-overflow flag.
module ks_nibble_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input logic                clk,
    input logic                rst_n,
    ks_nibble_seq_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  sum_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic          cout_q;
    logic          busy_q;
    logic          done_q;

    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [3:0]    na;
    logic [3:0]    nb;
    logic [3:0]    p;
    logic [3:0]    g;
    logic [3:0]    g1;
    logic [3:2]    p1;
    logic [3:0]    g2;
    logic [4:0]    c;
    logic [3:0]    ns;
    logic          last;

    // Current nibble of each operand, selected by the index register
    always_comb begin
        a_sh = a_q >> {idx_q, 2'b00};
        b_sh = b_q >> {idx_q, 2'b00};
        na   = a_sh[3:0];
        nb   = b_sh[3:0];
        last = (idx_q == IW'(NIBBLES - 1));
    end

    // Kogge-Stone core; carry-in folded into bit-0 generate
    always_comb begin
        p     = na ^ nb;
        g     = na & nb;
        g[0]  = g[0] | (p[0] & carry_q);
        g1[0] = g[0];
        g1[1] = g[1] | (p[1] & g[0]);
        g1[2] = g[2] | (p[2] & g[1]);
        g1[3] = g[3] | (p[3] & g[2]);
        p1[2] = p[2] & p[1];
        p1[3] = p[3] & p[2];
        g2[0] = g1[0];
        g2[1] = g1[1];
        g2[2] = g1[2] | (p1[2] & g1[0]);
        g2[3] = g1[3] | (p1[3] & g1[1]);
        c     = {g2, carry_q};
        ns    = p ^ c[3:0];
    end

`ifdef KS_SEQ_OVF_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef KS_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (bus.clr) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef KS_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.op_a;
                        b_q     <= bus.op_b;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
`ifdef KS_SEQ_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q*4 +: 4] <= ns;
                    carry_q             <= c[4];
                    if (last) begin
                        idx_q   <= '0;
                        cout_q  <= c[4];
`ifdef KS_SEQ_OVF_EN
                        ovf_q   <= c[3] ^ c[4];
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef KS_SEQ_OVF_EN
    assign bus.ovf  = ovf_q;
`else
    assign bus.ovf  = 1'b0;
`endif
endmodule

// File: doc/ks_nibble_seq_ctrl.md
KS_NIBBLE_SEQ_CTRL -- requirements
Module: ks_nibble_seq_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit nibbles (W = 4*NIBBLES, legal range 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port clr, input, 1, synchronous abort to IDLE.
REQ-006 SHALL have port op_a, input, W, first operand.
REQ-007 SHALL have port op_b, input, W, second operand.
REQ-008 SHALL have port cin, input, 1, carry into nibble 0.
REQ-009 SHALL have port sum, output, W, registered result.
REQ-010 SHALL have port cout, output, 1, registered carry out of the top nibble.
REQ-011 SHALL have port ovf, output, 1, registered signed overflow flag.
REQ-012 SHALL have port busy, output, 1, high while in RUN.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when a result becomes valid.

Function
REQ-014 SHALL compute sum/cout = op_a + op_b + cin by time-multiplexing one internal 4-bit parallel-prefix (Kogge-Stone: p=a^b, g=a&b, two prefix stages, carry-in folded into g[0]) adder over NIBBLES cycles, least significant nibble first.
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 In IDLE with start=1 and clr=0 at edge k: latch op_a, op_b and cin; clear nibble index and sum; enter RUN.
REQ-017 In RUN, each edge SHALL add nibble i of the latched operands with the carry register, write result nibble i into sum, update the carry register, and increment i.
REQ-018 After the nibble NIBBLES-1 update at edge k+NIBBLES: cout SHALL take the final carry, the FSM SHALL enter DONE, and done SHALL be 1 for exactly that one cycle.
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-020 Latency from start sampled to done asserted SHALL be exactly NIBBLES cycles; throughput is one addition per NIBBLES+2 cycles.
REQ-021 start in RUN or DONE SHALL be ignored and SHALL NOT be queued; operand inputs SHALL be don't-care after the start edge.
REQ-022 sum, cout and ovf SHALL hold their values from done until the next accepted start.
REQ-023 clr=1 in any state SHALL, at the next edge, force IDLE, zero sum/cout/ovf/carry/index and suppress done; clr takes priority over a simultaneous start.
REQ-024 The carry SHALL propagate across nibble boundaries with no loss; sum SHALL wrap modulo 2^W.
REQ-025 busy SHALL be 0 in IDLE and DONE.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, sum=0, cout=0, ovf=0, busy=0, done=0, and clear the carry and index registers, including mid-RUN; the aborted operation is discarded.
REQ-027 After rst_n deasserts, the first start SHALL be accepted on the first edge.

Configuration
REQ-028 Macro KS_SEQ_OVF_EN: when defined, ovf SHALL be set with cout as (carry into MSB) XOR (carry out of MSB) of the top nibble; when undefined, ovf SHALL be tied to 0 and no overflow logic is built.

Verification
REQ-029 NIBBLES=4: op_a=0x1234, op_b=0x4321, cin=0, start -> busy for 4 cycles, done at start edge +4, sum=0x5555, cout=0, ovf=0.
REQ-030 op_a=0xFFFF, op_b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all four nibbles).
REQ-031 With KS_SEQ_OVF_EN: op_a=0x7FFF, op_b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1; without the macro, ovf=0.
REQ-032 start pulsed again in RUN cycle 2 with new operands -> ignored, first result is unchanged, exactly one done pulse.
REQ-033 rst_n low in RUN cycle 2 -> all outputs 0 immediately; then clr=1 together with start in IDLE -> stays IDLE, busy=0, no done.
